// File: rtl/lane_stream_merge.sv
//==============================================================================
// Module      : lane_stream_merge
// Description : Merges NUM_LANES byte-lane streams into one tagged output
//               stream. A round-robin arbiter picks one lane per cycle; the
//               accepted beat goes into a one-entry output register. When
//               every lane has delivered its last beat, the merged stream
//               terminates and the block stays in DONE until reset.
//               Optional statistics counters: define LANE_MERGE_STATS_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module lane_stream_merge #(
    parameter int NUM_LANES = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_LANES-1:0]   in_valid,
    output logic [NUM_LANES-1:0]   in_ready,
    input  logic [8*NUM_LANES-1:0] in_byte,
    input  logic [NUM_LANES-1:0]   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_bits_idx,
    output logic [7:0]             out_bits_byte,
    output logic                   out_bits_last
`ifdef LANE_MERGE_STATS_EN
    ,
    output logic [31:0]            stat_beats,
    output logic [31:0]            stat_cycles
`endif
);

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_DONE = 1'b1
    } state_t;

    state_t                 r_state;
    logic [NUM_LANES-1:0]   r_done;
    logic [7:0]             r_ptr;
    logic                   r_out_valid;
    logic [7:0]             r_out_idx;
    logic [7:0]             r_out_byte;
    logic                   r_out_last;

    logic                   w_gnt_vld;
    logic [7:0]             w_gnt_idx;
    logic [NUM_LANES-1:0]   w_gnt_oh;
    logic [7:0]             w_gnt_byte;
    logic                   w_gnt_last;
    logic                   w_others_done;
    logic                   w_can_load;
    logic                   w_accept;
    logic                   w_final;

    // Round-robin arbiter: each lane gets a distance from (ptr+1); the
    // eligible lane with the smallest distance wins. Iterating over lanes
    // keeps every index constant.
    always_comb begin
        int v_best_d;
        int v_d;
        w_gnt_vld  = 1'b0;
        w_gnt_idx  = 8'd0;
        w_gnt_oh   = '0;
        w_gnt_byte = 8'd0;
        w_gnt_last = 1'b0;
        v_best_d   = NUM_LANES;
        v_d        = 0;
        for (int i = 0; i < NUM_LANES; i++) begin
            v_d = (i - int'(r_ptr) - 1 + 2 * NUM_LANES) % NUM_LANES;
            if (in_valid[i] && !r_done[i] && (v_d < v_best_d)) begin
                v_best_d   = v_d;
                w_gnt_vld  = 1'b1;
                w_gnt_idx  = 8'(i);
                w_gnt_oh   = '0;
                w_gnt_oh[i] = 1'b1;
                w_gnt_byte = in_byte[8*i +: 8];
                w_gnt_last = in_last[i];
            end
        end
        w_others_done = &(r_done | w_gnt_oh);
    end

    // Handshake qualification; in_ready is forced low while reset is held.
    always_comb begin
        w_can_load = !r_out_valid || out_ready;
        w_accept   = w_gnt_vld && w_can_load && (r_state == S_RUN);
        w_final    = w_accept && w_gnt_last && w_others_done;
        in_ready   = (w_accept && rst_n) ? w_gnt_oh : '0;
    end

    // Control FSM, done flags, RR pointer and the one-entry output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RUN;
            r_done      <= '0;
            r_ptr       <= 8'(NUM_LANES - 1);
            r_out_valid <= 1'b0;
            r_out_idx   <= 8'd0;
            r_out_byte  <= 8'd0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_idx   <= w_gnt_idx;
                r_out_byte  <= w_gnt_byte;
                r_out_last  <= w_final;
                r_ptr       <= w_gnt_idx;
                if (w_gnt_last) begin
                    r_done <= r_done | w_gnt_oh;
                end
                if (w_final) begin
                    r_state <= S_DONE;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid     = r_out_valid;
    assign out_bits_idx  = r_out_idx;
    assign out_bits_byte = r_out_byte;
    assign out_bits_last = r_out_last;

`ifdef LANE_MERGE_STATS_EN
    logic        w_out_hs;
    logic [31:0] r_stat_beats;
    logic [31:0] r_stat_cycles;
    logic        r_stat_run;
    logic        r_stat_fin;

    assign w_out_hs = r_out_valid && out_ready;

    // Beat counter plus a cycle counter spanning first to last handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_beats  <= 32'd0;
            r_stat_cycles <= 32'd0;
            r_stat_run    <= 1'b0;
            r_stat_fin    <= 1'b0;
        end else begin
            if (w_out_hs) begin
                r_stat_beats <= r_stat_beats + 32'd1;
            end
            if ((w_out_hs || r_stat_run) && !r_stat_fin) begin
                r_stat_cycles <= r_stat_cycles + 32'd1;
            end
            if (w_out_hs && !r_stat_fin) begin
                r_stat_run <= 1'b1;
            end
            if (w_out_hs && r_out_last) begin
                r_stat_fin <= 1'b1;
                r_stat_run <= 1'b0;
            end
        end
    end

    assign stat_beats  = r_stat_beats;
    assign stat_cycles = r_stat_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_lane_stream_merge.sv
//==============================================================================
// Module      : tb_lane_stream_merge
// Description : Directed self-checking bench for lane_stream_merge
//               (8-lane instance plus a 1-lane register-slice instance).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_lane_stream_merge;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [8*N-1:0] in_byte;
    logic [N-1:0]   in_last;
    logic           out_valid;
    logic           out_ready;
    logic [7:0]     out_bits_idx;
    logic [7:0]     out_bits_byte;
    logic           out_bits_last;

    logic [0:0]     v1, rdy1, l1;
    logic [7:0]     b1;
    logic           ov1, or1, ol1;
    logic [7:0]     oi1, ob1;

`ifdef LANE_MERGE_STATS_EN
    logic [31:0]    stat_beats, stat_cycles, s1_beats, s1_cycles;
`endif

    int checks   = 0;
    int failures = 0;
    int cnt [N];

    always #5 clk = ~clk;

    lane_stream_merge #(.NUM_LANES(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bits_idx(out_bits_idx), .out_bits_byte(out_bits_byte), .out_bits_last(out_bits_last)
`ifdef LANE_MERGE_STATS_EN
        , .stat_beats(stat_beats), .stat_cycles(stat_cycles)
`endif
    );

    lane_stream_merge #(.NUM_LANES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v1), .in_ready(rdy1), .in_byte(b1), .in_last(l1),
        .out_valid(ov1), .out_ready(or1),
        .out_bits_idx(oi1), .out_bits_byte(ob1), .out_bits_last(ol1)
`ifdef LANE_MERGE_STATS_EN
        , .stat_beats(s1_beats), .stat_cycles(s1_cycles)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = '0;
        in_last   = '0;
        in_byte   = '0;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        tick();
        rst_n = 1'b1;
    endtask

    // Lane i offers beats 0..nbeats-1, byte = i*16 + beat number.
    task automatic drive_model(input int nbeats);
        for (int i = 0; i < N; i++) begin
            in_valid[i]       = (cnt[i] < nbeats);
            in_last[i]        = (cnt[i] == nbeats - 1);
            in_byte[8*i +: 8] = 8'(i * 16 + cnt[i]);
        end
    endtask

    task automatic count_accepts();
        for (int i = 0; i < N; i++)
            if (in_valid[i] && in_ready[i]) cnt[i]++;
    endtask

    initial begin
        int exp_sd [7];
        int seen;
        exp_sd = '{1, 2, 3, 1, 3, 1, 3};

        rst_n = 1'b0; in_valid = '1; in_last = '0; in_byte = '0; out_ready = 1'b1;
        v1 = 1'b0; l1 = 1'b0; b1 = 8'h00; or1 = 1'b1;
        #2;
        // reset state
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_idx",       32'(out_bits_idx), 32'd0);
        check("rst_byte",      32'(out_bits_byte), 32'd0);
        check("rst_last",      32'(out_bits_last), 32'd0);
        check("rst_in_ready",  32'(in_ready), 32'd0);
        tick();
        rst_n = 1'b1;

        // fairness: all lanes valid, expect 0..7,0..7
        in_valid = '1; in_last = '0;
        for (int i = 0; i < N; i++) in_byte[8*i +: 8] = 8'(16 + i);
        for (int k = 0; k < 16; k++) begin
            #1;
            check("fair_in_ready", 32'(in_ready), 32'd1 << (k % 8));
            tick();
            check("fair_valid", 32'(out_valid), 32'd1);
            check("fair_idx",   32'(out_bits_idx), 32'(k % 8));
            check("fair_byte",  32'(out_bits_byte), 32'(16 + k % 8));
        end

        // termination: 3 beats per lane, 24 beats total
        do_reset();
        for (int n = 0; n < 24; n++) begin
            drive_model(3);
            #1;
            check("term_in_ready", 32'(in_ready), 32'd1 << (n % 8));
            count_accepts();
            tick();
            check("term_valid", 32'(out_valid), 32'd1);
            check("term_idx",   32'(out_bits_idx), 32'(n % 8));
            check("term_byte",  32'(out_bits_byte), 32'((n % 8) * 16 + n / 8));
            check("term_last",  32'(out_bits_last), (n == 23) ? 32'd1 : 32'd0);
        end
        in_valid = '1; in_last = '0;
        #1;
        check("term_done_ready", 32'(in_ready), 32'd0);
        tick();
        check("term_drained", 32'(out_valid), 32'd0);
        #1;
        check("term_done_ready2", 32'(in_ready), 32'd0);

        // skip done: lane 2 finishes on its first beat but stays valid
        do_reset();
        in_valid = 8'h0E; in_last = 8'h04;
        for (int i = 0; i < N; i++) in_byte[8*i +: 8] = 8'(32 + i);
        for (int k = 0; k < 7; k++) begin
            #1;
            check("skip_in_ready", 32'(in_ready), 32'd1 << exp_sd[k]);
            tick();
            check("skip_idx",  32'(out_bits_idx), 32'(exp_sd[k]));
            check("skip_byte", 32'(out_bits_byte), 32'(32 + exp_sd[k]));
            check("skip_last", 32'(out_bits_last), 32'd0);
        end

        // backpressure: lane 3 beat 0xA5 held for 5 cycles
        do_reset();
        in_valid = 8'h08; in_byte[31:24] = 8'hA5;
        #1;
        check("bp_in_ready0", 32'(in_ready), 32'h08);
        tick();
        check("bp_byte0", 32'(out_bits_byte), 32'hA5);
        in_byte[31:24] = 8'h5A; out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            tick();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_idx",   32'(out_bits_idx), 32'd3);
            check("bp_byte",  32'(out_bits_byte), 32'hA5);
        end
        out_ready = 1'b1;
        #1;
        check("bp_in_ready1", 32'(in_ready), 32'h08);
        tick();
        check("bp_byte1", 32'(out_bits_byte), 32'h5A);
        in_valid = '0;
        #1;
        check("bp_in_ready2", 32'(in_ready), 32'd0);
        tick();
        check("bp_no_dup", 32'(out_valid), 32'd0);

        // mid-stream reset (pointer is at lane 3, so lane 4 goes first)
        in_valid = 8'hF0;
        tick();
        check("mr_pre_idx",   32'(out_bits_idx), 32'd4);
        check("mr_pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_valid",    32'(out_valid), 32'd0);
        check("mr_idx",      32'(out_bits_idx), 32'd0);
        check("mr_byte",     32'(out_bits_byte), 32'd0);
        check("mr_last",     32'(out_bits_last), 32'd0);
        check("mr_in_ready", 32'(in_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        in_valid = '1;
        #1;
        check("mr_first_grant", 32'(in_ready), 32'h01);
        tick();
        check("mr_first_idx", 32'(out_bits_idx), 32'd0);
        in_valid = '0;

        // single-lane instance acts as a register slice
        v1 = 1'b1; b1 = 8'h77; or1 = 1'b1;
        #1;
        check("one_ready", 32'(rdy1), 32'd1);
        tick();
        check("one_valid", 32'(ov1), 32'd1);
        check("one_idx",   32'(oi1), 32'd0);
        check("one_byte",  32'(ob1), 32'h77);
        or1 = 1'b0; b1 = 8'h78;
        #1;
        check("one_ready_bp", 32'(rdy1), 32'd0);
        tick();
        check("one_byte_hold", 32'(ob1), 32'h77);
        v1 = 1'b0; or1 = 1'b1;

`ifdef LANE_MERGE_STATS_EN
        // stats: 16 beats, out_ready toggling 1,0
        do_reset();
        check("st_beats_rst",  stat_beats, 32'd0);
        check("st_cycles_rst", stat_cycles, 32'd0);
        out_ready = 1'b0;
        drive_model(2);
        #1;
        count_accepts();
        tick();
        seen = 0;
        for (int c = 0; c < 100 && seen < 16; c++) begin
            out_ready = (c % 2 == 0);
            drive_model(2);
            #1;
            if (out_valid && out_ready) seen++;
            count_accepts();
            tick();
        end
        check("st_seen", 32'(seen), 32'd16);
        out_ready = 1'b1;
        tick();
        tick();
        check("st_beats",  stat_beats, 32'd16);
        check("st_cycles", stat_cycles, 32'd31);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
